// File: rtl/mouse_draw_pkg.sv
// Shared definitions for the mouse cursor / canvas ink path.
//   state_e  : write-sequencer FSM states
//   cell_t   : canvas cell coordinate (row, col)
//   GRID_N   : cells per canvas side
//   CELL_W   : width of a cell coordinate
//   BTN_*    : bit positions inside the decoded packet button field
package mouse_draw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INK,
    CLEAR
  } state_e;

  localparam int GRID_N = 28;
  localparam int CELL_W = 5;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_MID   = 2;

  typedef struct packed {
    logic [CELL_W-1:0] row;
    logic [CELL_W-1:0] col;
  } cell_t;

endpackage

// File: rtl/cursor_accum.sv
// One axis of the cursor position integrator.
// Sign-extends a 9-bit two's-complement delta, adds it to (or subtracts it
// from, when SUB=1) the held position and clamps the result to [0, MAX].
// Ports:
//   clk, reset : clock, synchronous active-high reset (pos -> INIT)
//   pkt_valid  : apply delta this cycle
//   delta      : 9-bit signed movement
//   pos        : registered absolute position
module cursor_accum #(
  parameter int MAX  = 639,
  parameter int INIT = 320,
  parameter int SUB  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [8:0] delta,
  output logic [9:0] pos
);

  localparam logic signed [11:0] MAX_S = 12'(MAX);

  logic [9:0]         pos_q, pos_d;
  logic signed [11:0] delta_ext;
  logic signed [11:0] pos_ext;
  logic signed [11:0] sum;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    delta_ext = {{3{delta[8]}}, delta};
    pos_ext   = {2'b00, pos_q};
    sum       = (SUB != 0) ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
    pos_d     = pos_q;
    if (pkt_valid) begin
      if (sum < 0) begin
        pos_d = '0;
      end else if (sum > MAX_S) begin
        pos_d = MAX_S[9:0];
      end else begin
        pos_d = sum[9:0];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= 10'(INIT);
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/mouse_cursor_draw.sv
// Integrates decoded PS/2 mouse packets into a clamped screen cursor and
// turns left-button drags over the canvas into single-cell ink writes; a
// right-button press walks a full row-major clear of the 28x28 bitmap.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   pkt_valid, dx, dy  : decoded packet pulse and signed deltas (dy +up)
//   btn                : {middle, right, left}
//   cursor_x, cursor_y : absolute cursor position
//   wr_valid/wr_ready  : canvas write handshake
//   wr_row, wr_col     : target cell, wr_data : 1 = ink, 0 = clear
//   clear_busy         : clear sequence in progress
//   drop_cnt           : saturating count of ink/clear events lost while busy
//                        with an ink write
module mouse_cursor_draw #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240,
  parameter int CANVAS_X0 = 96,
  parameter int CANVAS_Y0 = 16,
  parameter int CELL_LOG2 = 4,
  parameter int GRID_N    = mouse_draw_pkg::GRID_N
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  input  logic [2:0] btn,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [4:0] wr_row,
  output logic [4:0] wr_col,
  output logic       wr_data,
  output logic       clear_busy,
  output logic [7:0] drop_cnt
);

  import mouse_draw_pkg::*;

  localparam int               CANVAS_PX = GRID_N << CELL_LOG2;
  localparam logic [9:0]       X_LO      = 10'(CANVAS_X0);
  localparam logic [9:0]       X_HI      = 10'(CANVAS_X0 + CANVAS_PX - 1);
  localparam logic [9:0]       Y_LO      = 10'(CANVAS_Y0);
  localparam logic [9:0]       Y_HI      = 10'(CANVAS_Y0 + CANVAS_PX - 1);
  localparam logic [CELL_W-1:0] LAST_IDX = CELL_W'(GRID_N - 1);

  // ---------------------------------------------------------------- cursor
  cursor_accum #(.MAX(SCREEN_W - 1), .INIT(X_INIT), .SUB(0)) u_acc_x (
    .clk      (clk),
    .reset    (reset),
    .pkt_valid(pkt_valid),
    .delta    (dx),
    .pos      (cursor_x)
  );

  // PS/2 dy is positive upward while screen y grows downward.
  cursor_accum #(.MAX(SCREEN_H - 1), .INIT(Y_INIT), .SUB(1)) u_acc_y (
    .clk      (clk),
    .reset    (reset),
    .pkt_valid(pkt_valid),
    .delta    (dy),
    .pos      (cursor_y)
  );

  // ------------------------------------------------------------- registers
  state_e      state_q, state_d;
  logic        pend_q, pend_d;          // a packet was applied last cycle
  logic [2:0]  btn_q, btn_d;            // buttons of that packet
  logic [2:0]  prev_btn_q, prev_btn_d;  // buttons of the packet before it
  logic        last_valid_q, last_valid_d;
  cell_t       last_cell_q, last_cell_d;
  logic        wr_valid_q, wr_valid_d;
  cell_t       wr_cell_q, wr_cell_d;
  logic        wr_data_q, wr_data_d;
  logic        clear_busy_q, clear_busy_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  // ---------------------------------------------------------- event decode
  logic [9:0] diff_x, diff_y;
  logic       in_canvas;
  cell_t      cur_cell;
  logic       clr_evt, ink_evt;

  always_comb begin
    diff_x       = cursor_x - X_LO;
    diff_y       = cursor_y - Y_LO;
    cur_cell.col = CELL_W'(diff_x >> CELL_LOG2);
    cur_cell.row = CELL_W'(diff_y >> CELL_LOG2);
    in_canvas    = (cursor_x >= X_LO) && (cursor_x <= X_HI) &&
                   (cursor_y >= Y_LO) && (cursor_y <= Y_HI);
    clr_evt      = pend_q && btn_q[BTN_RIGHT] && !prev_btn_q[BTN_RIGHT];
    ink_evt      = pend_q && btn_q[BTN_LEFT] && in_canvas &&
                   (!last_valid_q || (cur_cell != last_cell_q));
  end

  // Middle button and the stored left/middle history are carried for
  // completeness but never steer the datapath.
  logic unused_btn_bits;
  assign unused_btn_bits = ^{btn_q[BTN_MID], prev_btn_q[BTN_LEFT], prev_btn_q[BTN_MID]};

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d      = state_q;
    pend_d       = pkt_valid;
    btn_d        = pkt_valid ? btn : btn_q;
    prev_btn_d   = pend_q ? btn_q : prev_btn_q;
    last_valid_d = last_valid_q;
    last_cell_d  = last_cell_q;
    wr_valid_d   = wr_valid_q;
    wr_cell_d    = wr_cell_q;
    wr_data_d    = wr_data_q;
    clear_busy_d = clear_busy_q;
    drop_cnt_d   = drop_cnt_q;

    // Lifting the left button ends the stroke, so the next press re-inks
    // even the same cell.
    if (pend_q && !btn_q[BTN_LEFT]) begin
      last_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (clr_evt) begin
          state_d      = CLEAR;
          wr_valid_d   = 1'b1;
          wr_cell_d    = '0;
          wr_data_d    = 1'b0;
          clear_busy_d = 1'b1;
          last_valid_d = 1'b0;
        end else if (ink_evt) begin
          state_d      = INK;
          wr_valid_d   = 1'b1;
          wr_cell_d    = cur_cell;
          wr_data_d    = 1'b1;
          last_valid_d = 1'b1;
          last_cell_d  = cur_cell;
        end
      end

      INK: begin
        if (wr_ready) begin
          state_d    = IDLE;
          wr_valid_d = 1'b0;
        end
        // The pending write owns the port; new events are lost and counted.
        if ((ink_evt || clr_evt) && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end

      CLEAR: begin
        if (wr_ready) begin
          if ((wr_cell_q.row == LAST_IDX) && (wr_cell_q.col == LAST_IDX)) begin
            state_d      = IDLE;
            wr_valid_d   = 1'b0;
            clear_busy_d = 1'b0;
          end else if (wr_cell_q.col == LAST_IDX) begin
            wr_cell_d.col = '0;
            wr_cell_d.row = wr_cell_q.row + 1'b1;
          end else begin
            wr_cell_d.col = wr_cell_q.col + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      btn_q        <= '0;
      prev_btn_q   <= '0;
      last_valid_q <= 1'b0;
      last_cell_q  <= '0;
      wr_valid_q   <= 1'b0;
      wr_cell_q    <= '0;
      wr_data_q    <= 1'b0;
      clear_busy_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      btn_q        <= btn_d;
      prev_btn_q   <= prev_btn_d;
      last_valid_q <= last_valid_d;
      last_cell_q  <= last_cell_d;
      wr_valid_q   <= wr_valid_d;
      wr_cell_q    <= wr_cell_d;
      wr_data_q    <= wr_data_d;
      clear_busy_q <= clear_busy_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_row     = wr_cell_q.row;
  assign wr_col     = wr_cell_q.col;
  assign wr_data    = wr_data_q;
  assign clear_busy = clear_busy_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_mouse_cursor_draw.sv
// Directed bench for mouse_cursor_draw: cursor integration and clamping,
// back-to-back packets, ink writes, drops under backpressure, full clear and
// reset during a clear.
module tb_mouse_cursor_draw;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [8:0] dx, dy;
  logic [2:0] btn;
  logic [9:0] cursor_x, cursor_y;
  logic       wr_valid, wr_ready;
  logic [4:0] wr_row, wr_col;
  logic       wr_data;
  logic       clear_busy;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [10:0] wr_log[$];   // {row, col, data} of each accepted write

  always #5 clk = ~clk;

  mouse_cursor_draw dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .dx        (dx),
    .dy        (dy),
    .btn       (btn),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .clear_busy(clear_busy),
    .drop_cnt  (drop_cnt)
  );

  // Inputs change 1 ns after posedge, so at negedge they are stable and a
  // valid&ready seen here is the handshake of the coming edge.
  always @(negedge clk) begin
    if (wr_valid && wr_ready && !reset) wr_log.push_back({wr_row, wr_col, wr_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle packet; returns in the cycle its cursor result is visible.
  task automatic send_pkt(input int dxi, input int dyi, input logic [2:0] b);
    dx        = 9'(dxi);
    dy        = 9'(dyi);
    btn       = b;
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    if ({cursor_x, cursor_y} !== {10'd320, 10'd240}) begin
      errors++; $display("FAIL reset_cursor got (%0d,%0d) exp (320,240)", cursor_x, cursor_y);
    end
    checks++;
    if ({wr_valid, wr_row, wr_col, wr_data} !== 12'd0) begin
      errors++; $display("FAIL reset_wr got v=%b r=%0d c=%0d d=%b exp zeros", wr_valid, wr_row, wr_col, wr_data);
    end
    checks++;
    if ({clear_busy, drop_cnt} !== 9'd0) begin
      errors++; $display("FAIL reset_status got busy=%b drop=%0d exp 0,0", clear_busy, drop_cnt);
    end
    checks++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_move();
    int n0;
    n0 = wr_log.size();
    send_pkt(10, 5, 3'b000);
    if ({cursor_x, cursor_y} !== {10'd330, 10'd235}) begin
      errors++; $display("FAIL move_cursor got (%0d,%0d) exp (330,235)", cursor_x, cursor_y);
    end
    checks++;
    step();
    step();
    if (wr_valid !== 1'b0 || wr_log.size() != n0) begin
      errors++; $display("FAIL move_no_write got wr_valid=%b writes=%0d exp 0,%0d", wr_valid, wr_log.size(), n0);
    end
    checks++;
  endtask

  task automatic test_clamp();
    do_reset();
    send_pkt(-256, -256, 3'b000);
    if ({cursor_x, cursor_y} !== {10'd64, 10'd479}) begin
      errors++; $display("FAIL clamp_first got (%0d,%0d) exp (64,479)", cursor_x, cursor_y);
    end
    checks++;
    send_pkt(-256, -256, 3'b000);
    if ({cursor_x, cursor_y} !== {10'd0, 10'd479}) begin
      errors++; $display("FAIL clamp_second got (%0d,%0d) exp (0,479)", cursor_x, cursor_y);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    dx = 9'd100; dy = 9'd100; btn = 3'b000; pkt_valid = 1'b1;
    step();
    if ({cursor_x, cursor_y} !== {10'd420, 10'd140}) begin
      errors++; $display("FAIL b2b_1 got (%0d,%0d) exp (420,140)", cursor_x, cursor_y);
    end
    checks++;
    step();
    if ({cursor_x, cursor_y} !== {10'd520, 10'd40}) begin
      errors++; $display("FAIL b2b_2 got (%0d,%0d) exp (520,40)", cursor_x, cursor_y);
    end
    checks++;
    dx = 9'd200;
    step();
    pkt_valid = 1'b0;
    if ({cursor_x, cursor_y} !== {10'd639, 10'd0}) begin
      errors++; $display("FAIL b2b_3 got (%0d,%0d) exp (639,0)", cursor_x, cursor_y);
    end
    checks++;
    step();
    if ({cursor_x, cursor_y} !== {10'd639, 10'd0}) begin
      errors++; $display("FAIL b2b_hold got (%0d,%0d) exp (639,0)", cursor_x, cursor_y);
    end
    checks++;
  endtask

  task automatic test_ink();
    int n0;
    do_reset();
    wr_ready = 1'b1;
    send_pkt(-224, 224, 3'b000);
    if ({cursor_x, cursor_y} !== {10'd96, 10'd16}) begin
      errors++; $display("FAIL ink_corner got (%0d,%0d) exp (96,16)", cursor_x, cursor_y);
    end
    checks++;
    step();
    n0 = wr_log.size();
    send_pkt(0, 0, 3'b001);
    if (wr_valid !== 1'b0) begin
      errors++; $display("FAIL ink_latency_n1 got wr_valid=%b exp 0", wr_valid);
    end
    checks++;
    step();
    if ({wr_valid, wr_row, wr_col, wr_data} !== {1'b1, 5'd0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL ink_first got v=%b r=%0d c=%0d d=%b exp 1,0,0,1", wr_valid, wr_row, wr_col, wr_data);
    end
    checks++;
    step();
    if (wr_valid !== 1'b0 || wr_log.size() != n0 + 1) begin
      errors++; $display("FAIL ink_one_cycle got wr_valid=%b writes=%0d exp 0,%0d", wr_valid, wr_log.size() - n0, 1);
    end
    checks++;
    send_pkt(0, 0, 3'b001);     // same cell, button still held
    step(); step(); step();
    send_pkt(-1, 0, 3'b001);    // x=95, just left of canvas
    step(); step(); step();
    if (wr_log.size() != n0 + 1) begin
      errors++; $display("FAIL ink_repeat_outside got writes=%0d exp 1", wr_log.size() - n0);
    end
    checks++;
    send_pkt(17, 0, 3'b001);    // x=112 -> col 1
    step(); step(); step();
    if (wr_log.size() != n0 + 2 || wr_log[n0 + 1] !== {5'd0, 5'd1, 1'b1}) begin
      errors++; $display("FAIL ink_col1 got writes=%0d last=%h exp 2,%h", wr_log.size() - n0,
                         wr_log[wr_log.size() - 1], {5'd0, 5'd1, 1'b1});
    end
    checks++;
  endtask

  task automatic test_drop();
    int n0;
    n0 = wr_log.size();
    wr_ready = 1'b0;
    send_pkt(16, 0, 3'b001);    // x=128 -> (0,2)
    step();
    send_pkt(16, 0, 3'b001);    // x=144 -> (0,3), dropped
    step();
    send_pkt(0, -16, 3'b001);   // y=32  -> (1,3), dropped
    step();
    step();
    if ({wr_valid, wr_row, wr_col, wr_data} !== {1'b1, 5'd0, 5'd2, 1'b1}) begin
      errors++; $display("FAIL drop_hold got v=%b r=%0d c=%0d d=%b exp 1,0,2,1", wr_valid, wr_row, wr_col, wr_data);
    end
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++; $display("FAIL drop_count got %0d exp 2", drop_cnt);
    end
    checks++;
    wr_ready = 1'b1;
    step();
    step();
    step();
    if (wr_valid !== 1'b0 || wr_log.size() != n0 + 1 || wr_log[n0] !== {5'd0, 5'd2, 1'b1}) begin
      errors++; $display("FAIL drop_release got wr_valid=%b writes=%0d exp 0,1 entry (0,2,1)", wr_valid, wr_log.size() - n0);
    end
    checks++;
  endtask

  task automatic test_clear();
    int n0, bad, cyc;
    wr_ready = 1'b1;
    n0 = wr_log.size();
    send_pkt(0, 0, 3'b010);
    step();
    if ({clear_busy, wr_valid, wr_row, wr_col, wr_data} !== {1'b1, 1'b1, 5'd0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL clear_start got busy=%b v=%b r=%0d c=%0d d=%b exp 1,1,0,0,0",
                         clear_busy, wr_valid, wr_row, wr_col, wr_data);
    end
    checks++;
    repeat (50) step();
    send_pkt(0, 0, 3'b011);     // ink in canvas during clear: ignored
    cyc = 0;
    while (clear_busy === 1'b1 && cyc < 1000) begin
      step();
      cyc++;
    end
    if (clear_busy !== 1'b0 || wr_valid !== 1'b0) begin
      errors++; $display("FAIL clear_end got busy=%b wr_valid=%b exp 0,0 after %0d cycles", clear_busy, wr_valid, cyc);
    end
    checks++;
    if (wr_log.size() != n0 + 784) begin
      errors++; $display("FAIL clear_count got %0d writes exp 784", wr_log.size() - n0);
    end
    checks++;
    if (wr_log.size() >= n0 + 784) begin
      bad = 0;
      for (int i = 0; i < 784; i++) begin
        if (wr_log[n0 + i] !== {5'(i / 28), 5'(i % 28), 1'b0}) bad++;
      end
      if (bad != 0) begin
        errors++; $display("FAIL clear_order got %0d out-of-order entries exp 0", bad);
      end
      checks++;
      if (wr_log[n0 + 783] !== {5'd27, 5'd27, 1'b0}) begin
        errors++; $display("FAIL clear_last got %h exp %h", wr_log[n0 + 783], {5'd27, 5'd27, 1'b0});
      end
      checks++;
    end
    if (drop_cnt !== 8'd2) begin
      errors++; $display("FAIL clear_no_drop got drop=%0d exp 2", drop_cnt);
    end
    checks++;
    n0 = wr_log.size();
    send_pkt(0, 0, 3'b010);     // right still held: no edge
    repeat (4) step();
    if (clear_busy !== 1'b0 || wr_log.size() != n0) begin
      errors++; $display("FAIL clear_no_retrigger got busy=%b writes=%0d exp 0,0", clear_busy, wr_log.size() - n0);
    end
    checks++;
  endtask

  task automatic test_reset_mid_clear();
    int n0, cyc;
    send_pkt(0, 0, 3'b000);
    step();
    n0 = wr_log.size();
    send_pkt(0, 0, 3'b010);
    cyc = 0;
    while (wr_log.size() < n0 + 100 && cyc < 300) begin
      step();
      cyc++;
    end
    if (wr_valid !== 1'b1 || clear_busy !== 1'b1) begin
      errors++; $display("FAIL midclear_active got v=%b busy=%b exp 1,1", wr_valid, clear_busy);
    end
    checks++;
    reset = 1'b1;
    step();
    if (wr_valid !== 1'b0 || clear_busy !== 1'b0) begin
      errors++; $display("FAIL midclear_reset got v=%b busy=%b exp 0,0", wr_valid, clear_busy);
    end
    checks++;
    if ({cursor_x, cursor_y, drop_cnt} !== {10'd320, 10'd240, 8'd0}) begin
      errors++; $display("FAIL midclear_state got (%0d,%0d) drop=%0d exp (320,240) 0", cursor_x, cursor_y, drop_cnt);
    end
    checks++;
    reset = 1'b0;
    step();
    step();
    if (wr_valid !== 1'b0) begin
      errors++; $display("FAIL midclear_after got wr_valid=%b exp 0", wr_valid);
    end
    checks++;
  endtask

  initial begin
    reset     = 1'b1;
    pkt_valid = 1'b0;
    dx        = '0;
    dy        = '0;
    btn       = '0;
    wr_ready  = 1'b1;
    step();
    test_reset();
    test_move();
    test_clamp();
    test_back_to_back();
    test_ink();
    test_drop();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_draw.md
Name: mouse_cursor_draw

Overview:
- Sits directly downstream of the PS/2 mouse packet decoder.
- Consumes one decoded movement packet per pulse: 9-bit two's-complement dx/dy, 3 buttons and a done pulse.
- Integrates the deltas into a clamped absolute cursor position on screen.
- While the left button is held inside the drawing canvas, emits "ink" writes to the 28x28 digit bitmap over a valid/ready port. A right-button press sequences a full canvas clear through the same port.

Parameters:
SCREEN_W, 640, screen width in pixels; cursor_x range 0..SCREEN_W-1
SCREEN_H, 480, screen height in pixels; cursor_y range 0..SCREEN_H-1
X_INIT, 320, cursor_x after reset
Y_INIT, 240, cursor_y after reset
CANVAS_X0, 96, left pixel of canvas
CANVAS_Y0, 16, top pixel of canvas
CELL_LOG2, 4, log2 of cell edge in pixels (canvas = 28<<CELL_LOG2 square)
GRID_N, 28, cells per canvas side

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pkt_valid  in  1  one-cycle pulse: dx/dy/btn valid (decoder done pulse)
dx  in  9  x delta, two's complement, +right
dy  in  9  y delta, two's complement, +up (PS/2 convention)
btn  in  3  {middle,right,left}
cursor_x  out  10  absolute cursor x
cursor_y  out  10  absolute cursor y
wr_valid  out  1  canvas write request
wr_ready  in  1  canvas accepts write when wr_valid&&wr_ready
wr_row  out  5  cell row 0..27
wr_col  out  5  cell col 0..27
wr_data  out  1  1=ink, 0=clear
clear_busy  out  1  high while clear sequence runs
drop_cnt  out  8  saturating count of dropped ink events

Behaviour:
- Reset values:
  - cursor_x=X_INIT, cursor_y=Y_INIT
  - wr_valid=0, wr_row=0, wr_col=0, wr_data=0
  - clear_busy=0, drop_cnt=0
  - prev_btn=0, last_cell invalid, state IDLE
- Reset asserted mid-handshake abandons the request: wr_valid is 0 in the cycle after the reset edge.
- Cursor update, pkt_valid at cycle N, registered result visible at N+1:
  - Sign-extend to 12 bits; x' = x+dx, y' = y-dy (screen y grows downward).
  - Clamp each axis to [0, max]: negative result -> 0, result > max -> max.
  - The cursor updates on every packet regardless of FSM state.
- Event decode at cycle N+1, using the updated cursor and the registered packet buttons:
  - clr_evt = btn[1] && !prev_btn[1] (rising edge across packets).
  - ink_evt = btn[0] && cursor inside [X0, X0+(28<<L)-1] x [Y0, Y0+(28<<L)-1] && cell != last_cell.
  - Cell: col=(x-X0)>>CELL_LOG2, row=(y-Y0)>>CELL_LOG2.
  - Packet with btn[0]=0 invalidates last_cell.
  - prev_btn <= btn each packet.
- FSM states:
  - IDLE:
    - clr_evt -> CLEAR: row=col=0, wr_data=0, wr_valid=1, clear_busy=1, last_cell invalid. clr_evt wins over ink_evt; the ink is discarded and not counted.
    - Otherwise ink_evt -> INK: wr_row/col=cell, wr_data=1, wr_valid=1, last_cell=cell.
    - wr_valid rises at N+2 relative to pkt_valid.
  - INK:
    - Hold wr_* stable until wr_valid&&wr_ready; then wr_valid=0 -> IDLE.
    - ink_evt or clr_evt arriving while in INK: dropped; drop_cnt += 1, saturating at 255. last_cell is not updated for a dropped ink.
  - CLEAR:
    - Each accepted handshake advances col. At col 27, col wraps to 0 and row increments.
    - The handshake at row 27 col 27 -> IDLE: wr_valid=0, clear_busy=0.
    - Exactly 784 writes, row-major.
    - ink/clr events during CLEAR are ignored and not counted.
- With wr_ready tied high, an ink write completes in one cycle, and a clear takes 784 cycles.
- Back-to-back packets (pkt_valid every cycle) must still update the cursor correctly.

Decomposition:
- Shared package mouse_draw_pkg:
  - FSM state enum {IDLE, INK, CLEAR}.
  - GRID_N and cell-coordinate width constant (5).
  - Packet button bit indices (BTN_LEFT=0, BTN_RIGHT=1, BTN_MID=2).
- One sub-module, cursor_accum: one instance per axis, holding sign-extend, add/sub and clamp. Parameters MAX, INIT, SUB (1 for the y axis).

Test Plan:
- Reset, then packet dx=+10, dy=+5, btn=0 -> cursor (330,235) one cycle after pkt_valid; wr_valid stays 0.
- From reset, dx=-256 twice, dy=-256 twice -> cursor_x clamps to 0 after the 2nd packet (320-512<0); cursor_y=479 after the 2nd packet (240+512 clamped).
- Cursor at (96,16), packet dx=0, dy=0, btn=001 with wr_ready=1 -> one write row=0, col=0, data=1 at N+2. Repeating the identical packet -> no write. Packet dx=+16 -> write col=1.
- wr_ready held 0 during ink, two further ink packets into new cells -> wr_* stable, drop_cnt=2. Releasing wr_ready completes the original write only.
- Packet btn=010 (right edge) with wr_ready=1 -> clear_busy high; 784 writes with data=0; first write (0,0), last (27,27); then clear_busy=0. A second btn=010 packet without release -> no new clear.
- Assert reset during CLEAR at write ~100 -> wr_valid=0 and clear_busy=0 next cycle; cursor=(320,240); drop_cnt=0.
